alu_seq: RTL and testbench

Parametrised, registered successor to the team's combinational 4-bit ALU. It is `WIDTH` bits wide and has a stored condition-flag register, so the carry chains across operations (ADC/SBC). It adds a multi-cycle shift-add multiplier controlled by a two-state FSM. It sits between the register file and the writeback stage of the lab datapath, and uses a start/busy/done handshake.

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a stored {N,Z,Cy,V} flag register.
// Carry chains across operations through ADC/SBC. MUL is a multi-cycle
// shift-add multiplier sequenced by a two-state FSM with a start/busy/done
// handshake.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [3:0]       Cond,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_ADC = 4'b1000;
    localparam logic [3:0] OP_SBC = 4'b1001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               mul_last;
    logic [WIDTH+3:0]   eval;

    // Pack a result with its flag nibble {N, Z, Cy, V}.
    function automatic logic [WIDTH+3:0] pack_flags(input logic [WIDTH-1:0] res,
                                                    input logic cy,
                                                    input logic v);
        return {res[WIDTH-1], (res == '0), cy, v, res};
    endfunction

    // Single-cycle operations. cy_in is the stored carry used by ADC/SBC.
    function automatic logic [WIDTH+3:0] alu_eval(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             cy_in);
        logic [WIDTH-1:0] bop;
        logic [WIDTH-1:0] res;
        logic [WIDTH:0]   sum;
        logic             cin;
        logic             cy;
        logic             v;
        bop = b;
        cin = 1'b0;
        res = '0;
        cy  = 1'b0;
        v   = 1'b0;
        case (op)
            OP_SUB:  begin bop = ~b; cin = 1'b1;  end
            OP_ADC:  begin bop = b;  cin = cy_in; end
            OP_SBC:  begin bop = ~b; cin = cy_in; end
            default: begin bop = b;  cin = 1'b0;  end
        endcase
        // Subtracts reuse the adder with an inverted B, so carry-out 1 = no borrow.
        sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                v   = (a[WIDTH-1] == bop[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res = {a[WIDTH-2:0], 1'b0};
                cy  = a[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, a[WIDTH-1:1]};
                cy  = a[0];
            end
            default: res = '0;
        endcase
        return pack_flags(res, cy, v);
    endfunction

    // Opcodes 1010-1111 complete (done pulses) but leave C/Cond untouched.
    function automatic logic op_writes(input logic [3:0] op);
        return (op <= OP_SBC) && (op != OP_MUL);
    endfunction

    assign accept   = (state == S_IDLE) && start;
    assign mul_last = (state == S_MUL) && (cnt == CNT_W'(1));
    assign eval     = alu_eval(ALUop, A, B, Cond[1]);

    // Multiplier step: conditionally add the shifted multiplicand.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and busy output.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (ALUop == OP_MUL)) begin
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Multiplier operand/accumulator registers; no reset needed, loaded at acceptance.
    always_ff @(posedge clk) begin
        if (accept && (ALUop == OP_MUL)) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Result, flags, done pulse and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C    <= '0;
            Cond <= 4'b0000;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (ALUop == OP_MUL) begin
                    cnt <= CNT_W'(WIDTH);
                end else begin
                    done <= 1'b1;
                    if (op_writes(ALUop)) begin
                        C    <= eval[WIDTH-1:0];
                        Cond <= eval[WIDTH+3:WIDTH];
                    end
                end
            end else if (state == S_MUL) begin
                cnt <= cnt - CNT_W'(1);
                if (mul_last) begin
                    done <= 1'b1;
                    C    <= acc_next[WIDTH-1:0];
                    Cond <= {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0),
                             (acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=4): vector table for single-cycle ops
// plus hand-written sequences for multiply, reset and busy corner cases.
module tb_alu_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   ALUop;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [3:0]   Cond;
    logic         busy;
    logic         done;

    int total;
    int passed;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_c;
        logic [3:0]   exp_cond;
    } vec_t;

    vec_t vecs[15];

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ALUop (ALUop),
        .A     (A),
        .B     (B),
        .C     (C),
        .Cond  (Cond),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept a MUL; optionally poke an ADD and new operands while busy.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_c, input logic [3:0] exp_cond,
                           input bit poke);
        int n;
        @(negedge clk);
        start = 1'b1; ALUop = 4'b0111; A = a; B = b;
        @(posedge clk); #1;
        check("mul_busy_accept", busy, 1);
        check("mul_no_done_accept", done, 0);
        @(negedge clk);
        if (poke) begin
            start = 1'b1; ALUop = 4'b0000; A = 4'h1; B = 4'h1;
        end else begin
            start = 1'b0;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 2) begin
                @(negedge clk);
                start = 1'b0; A = 4'hF; B = 4'hF;
                @(posedge clk); #1;
                n++;
            end
        end while (!done && n < 20);
        check("mul_latency", n, 4);
        check("mul_busy_done", busy, 0);
        check("mul_c", C, exp_c);
        check("mul_cond", Cond, exp_cond);
        @(posedge clk); #1;
        check("mul_done_single", done, 0);
        check("mul_c_hold", C, exp_c);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst = 1'b1; start = 1'b0; ALUop = 4'h0; A = '0; B = '0;

        vecs[0]  = '{4'b0000, 4'hF, 4'h1, 4'h0, 4'b0110};  // ADD wrap
        vecs[1]  = '{4'b0000, 4'h7, 4'h1, 4'h8, 4'b1001};  // ADD overflow
        vecs[2]  = '{4'b0001, 4'h8, 4'h1, 4'h7, 4'b0011};  // SUB overflow, no borrow
        vecs[3]  = '{4'b0001, 4'h0, 4'h1, 4'hF, 4'b1000};  // SUB borrow
        vecs[4]  = '{4'b1001, 4'h0, 4'h0, 4'hF, 4'b1000};  // SBC with Cy=0
        vecs[5]  = '{4'b0000, 4'hF, 4'h1, 4'h0, 4'b0110};  // ADD sets Cy
        vecs[6]  = '{4'b1000, 4'h0, 4'h0, 4'h1, 4'b0000};  // ADC forwards Cy=1
        vecs[7]  = '{4'b0010, 4'hC, 4'hA, 4'h8, 4'b1000};  // AND
        vecs[8]  = '{4'b0011, 4'h5, 4'hA, 4'hF, 4'b1000};  // OR
        vecs[9]  = '{4'b0100, 4'hF, 4'hF, 4'h0, 4'b0100};  // XOR zero
        vecs[10] = '{4'b0101, 4'h9, 4'h0, 4'h2, 4'b0010};  // SHL out bit 1
        vecs[11] = '{4'b0110, 4'h3, 4'h0, 4'h1, 4'b0010};  // SHR out bit 1
        vecs[12] = '{4'b0000, 4'h3, 4'h4, 4'h7, 4'b0000};  // ADD
        vecs[13] = '{4'b1100, 4'h5, 4'h5, 4'h7, 4'b0000};  // illegal holds
        vecs[14] = '{4'b1111, 4'hF, 4'hF, 4'h7, 4'b0000};  // illegal holds

        #12;
        check("rst_c", C, 0);
        check("rst_cond", Cond, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back single-cycle ops, start held high throughout.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start = 1'b1; ALUop = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            @(posedge clk); #1;
            check($sformatf("vec%0d_done", i), done, 1);
            check($sformatf("vec%0d_c", i), C, vecs[i].exp_c);
            check($sformatf("vec%0d_cond", i), Cond, vecs[i].exp_cond);
        end

        // Asynchronous reset mid-cycle, while done and C are nonzero.
        #2 rst = 1'b1;
        #1;
        check("async_rst_c", C, 0);
        check("async_rst_cond", Cond, 0);
        check("async_rst_done", done, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        run_mul(4'h6, 4'h9, 4'h6, 4'b0010, 1'b0);
        run_mul(4'h3, 4'h5, 4'hF, 4'b1000, 1'b0);
        run_mul(4'h6, 4'h9, 4'h6, 4'b0010, 1'b1);

        // Reset two cycles into a MUL.
        @(negedge clk);
        start = 1'b1; ALUop = 4'b0111; A = 4'h6; B = 4'h9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mulrst_busy", busy, 0);
        check("mulrst_c", C, 0);
        check("mulrst_cond", Cond, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("mulrst_nodone%0d", i), done, 0);
            check($sformatf("mulrst_idle%0d", i), busy, 0);
        end

        // Idle restored: a plain ADD completes next cycle.
        @(negedge clk);
        start = 1'b1; ALUop = 4'b0000; A = 4'h2; B = 4'h3;
        @(posedge clk); #1;
        check("post_rst_done", done, 1);
        check("post_rst_c", C, 4'h5);
        check("post_rst_cond", Cond, 4'b0000);
        @(negedge clk);
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
